// File: rtl/dac_seq_pkg.sv
// Shared types and defaults for the DAC burst sequencer.
package dac_seq_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int MIN_PTOS_DEF = 4;

  localparam logic SEL_SENO  = 1'b0;
  localparam logic SEL_CONST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic ptos_ok(input logic [15:0] p, input int unsigned min_p);
    return 32'(p) >= min_p;
  endfunction

endpackage

// File: rtl/dac_seq_cycle_counter.sv
// Sample-within-cycle and completed-cycle counters with terminal-count flag.
module dac_seq_cycle_counter #(
  parameter int CNT_W  = 16,
  parameter int PTOS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [PTOS_W-1:0] i_ptos,
  input  logic [CNT_W-1:0]  i_n_ciclos,
  output logic [CNT_W-1:0]  o_ciclos,
  output logic              o_tc
);

  logic [PTOS_W-1:0] r_samp;
  logic [CNT_W-1:0]  r_ciclos;
  logic              w_wrap;

  assign w_wrap   = (r_samp == i_ptos - PTOS_W'(1));
  // tc means the next counted sample completes the final cycle
  assign o_tc     = w_wrap && (r_ciclos == i_n_ciclos - CNT_W'(1));
  assign o_ciclos = r_ciclos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp   <= '0;
      r_ciclos <= '0;
    end else if (i_clr) begin
      r_samp   <= '0;
      r_ciclos <= '0;
    end else if (i_inc) begin
      if (w_wrap) begin
        r_samp   <= '0;
        r_ciclos <= r_ciclos + CNT_W'(1);
      end else begin
        r_samp   <= r_samp + PTOS_W'(1);
      end
    end
  end

endmodule

// File: rtl/dac_burst_sequencer.sv
// Burst controller in front of the DAC driver: reset/config settle, release, count N cycles.
// Optional SETTLE watchdog enabled by defining DAC_SEQ_TIMEOUT_EN.
module dac_burst_sequencer
  import dac_seq_pkg::*;
#(
  parameter int CFG_SETUP      = 4,
  parameter int MIN_PTOS       = MIN_PTOS_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             CLK_65,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      cfg_ptos_x_ciclo,
  input  logic             cfg_seleccion_dac,
  input  logic [CNT_W-1:0] cfg_n_ciclos,
  input  logic             dac_valid_in,
  output logic             dac_reset_n,
  output logic             dac_enable,
  output logic [15:0]      ptos_x_ciclo,
  output logic             seleccion_dac,
  output logic             window,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] ciclos_hechos
);

  localparam int SETUP_W = (CFG_SETUP > 1) ? $clog2(CFG_SETUP) : 1;

  state_t             r_state, w_next;
  logic [SETUP_W-1:0] r_setup_cnt;
  logic [15:0]        r_ptos;
  logic               r_sel;
  logic [CNT_W-1:0]   r_n_ciclos;
  logic               r_dac_on, r_window, r_busy, r_done, r_err;

  logic               w_req_ok, w_accept, w_setup_last, w_inc, w_tc, w_timeout;
  logic               w_dac_on_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
  logic [CNT_W-1:0]   w_ciclos;

  assign w_req_ok     = ptos_ok(cfg_ptos_x_ciclo, MIN_PTOS) && (cfg_n_ciclos != '0);
  assign w_accept     = (r_state == ST_IDLE) && start && w_req_ok;
  assign w_setup_last = (r_setup_cnt == SETUP_W'(CFG_SETUP - 1));
  // first valid in SETTLE is already sample 0; abort suppresses counting
  assign w_inc        = ((r_state == ST_SETTLE) || (r_state == ST_RUN)) && dac_valid_in && !abort;

`ifdef DAC_SEQ_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_last;

  assign w_wd_last = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_timeout = (r_state == ST_SETTLE) && !dac_valid_in && !abort && w_wd_last;

  always_ff @(posedge CLK_65 or posedge reset) begin
    if (reset)                                      r_wd_cnt <= '0;
    else if ((r_state == ST_SETTLE) && !w_wd_last)  r_wd_cnt <= r_wd_cnt + WD_W'(1);
    else                                            r_wd_cnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK_65 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_SETUP;
      ST_SETUP:  if (abort) w_next = ST_IDLE;
                 else if (w_setup_last) w_next = ST_SETTLE;
      ST_SETTLE: if (abort || w_timeout) w_next = ST_IDLE;
                 else if (dac_valid_in) w_next = w_tc ? ST_DONE : ST_RUN;
      ST_RUN:    if (abort) w_next = ST_IDLE;
                 else if (dac_valid_in && w_tc) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // outputs are decoded from the next state so the registers track the state exactly
  always_comb begin
    w_dac_on_nxt = (w_next == ST_SETTLE) || (w_next == ST_RUN);
    w_busy_nxt   = (w_next != ST_IDLE);
    w_done_nxt   = (w_next == ST_DONE);
    w_err_nxt    = ((r_state == ST_IDLE) && start && !w_req_ok) || w_timeout;
  end

  always_ff @(posedge CLK_65 or posedge reset) begin
    if (reset) begin
      r_dac_on <= 1'b0;
      r_window <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_dac_on <= w_dac_on_nxt;
      r_window <= w_inc;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_ff @(posedge CLK_65 or posedge reset) begin
    if (reset)                                            r_setup_cnt <= '0;
    else if ((r_state == ST_SETUP) && !w_setup_last)      r_setup_cnt <= r_setup_cnt + SETUP_W'(1);
    else                                                  r_setup_cnt <= '0;
  end

  always_ff @(posedge CLK_65 or posedge reset) begin
    if (reset) begin
      r_ptos     <= '0;
      r_sel      <= 1'b0;
      r_n_ciclos <= '0;
    end else if (w_accept) begin
      r_ptos     <= cfg_ptos_x_ciclo;
      r_sel      <= cfg_seleccion_dac;
      r_n_ciclos <= cfg_n_ciclos;
    end
  end

  dac_seq_cycle_counter #(.CNT_W(CNT_W), .PTOS_W(16)) u_cnt (
    .clk        (CLK_65),
    .rst        (reset),
    .i_clr      (w_accept),
    .i_inc      (w_inc),
    .i_ptos     (r_ptos),
    .i_n_ciclos (r_n_ciclos),
    .o_ciclos   (w_ciclos),
    .o_tc       (w_tc)
  );

  assign dac_reset_n   = r_dac_on;
  assign dac_enable    = r_dac_on;
  assign ptos_x_ciclo  = r_ptos;
  assign seleccion_dac = r_sel;
  assign window        = r_window;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign ciclos_hechos = w_ciclos;

endmodule

// File: tb/tb_dac_burst_sequencer.sv
// Directed bench for dac_burst_sequencer with a sample-count based reference model.
module tb_dac_burst_sequencer;
  import dac_seq_pkg::*;

  localparam int CW    = 16;
  localparam int SETUP = 4;
`ifdef DAC_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          CLK_65 = 1'b0;
  logic          reset  = 1'b1;
  logic          start  = 1'b0;
  logic          abort  = 1'b0;
  logic [15:0]   ptos   = '0;
  logic          sel    = 1'b0;
  logic [CW-1:0] ncyc   = '0;
  logic          valid  = 1'b0;

  logic          dac_reset_n, dac_enable, seleccion_dac, window, busy, done, err;
  logic [15:0]   ptos_x_ciclo;
  logic [CW-1:0] ciclos_hechos;

  always #5 CLK_65 = ~CLK_65;

  dac_burst_sequencer #(.CFG_SETUP(SETUP), .MIN_PTOS(MIN_PTOS_DEF), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_65(CLK_65), .reset(reset), .start(start), .abort(abort),
    .cfg_ptos_x_ciclo(ptos), .cfg_seleccion_dac(sel), .cfg_n_ciclos(ncyc),
    .dac_valid_in(valid), .dac_reset_n(dac_reset_n), .dac_enable(dac_enable),
    .ptos_x_ciclo(ptos_x_ciclo), .seleccion_dac(seleccion_dac), .window(window),
    .busy(busy), .done(done), .err(err), .ciclos_hechos(ciclos_hechos)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a burst is "total samples counted k"; cycles done = k/ptos, finished at k = ptos*n.
  int            m_phase = 0;   // 0 idle, 1 setup, 2 settle, 3 run, 4 done
  int            m_setup = 0;
  int            m_wd    = 0;
  longint        m_k     = 0;
  logic [CW-1:0] m_n     = '0;
  logic [15:0]   e_ptos  = '0;
  logic          e_sel = 1'b0, e_win = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0, e_en = 1'b0;
  logic [CW-1:0] e_cyc   = '0;

  always @(posedge CLK_65 or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_k = 0; e_ptos = '0; e_sel = 1'b0; e_cyc = '0;
      e_win = 1'b0; e_err = 1'b0;
    end else begin
      e_win = 1'b0; e_err = 1'b0;
      case (m_phase)
        0: if (start) begin
             if (ptos < MIN_PTOS_DEF || ncyc == 0) e_err = 1'b1;
             else begin
               e_ptos = ptos; e_sel = sel; m_n = ncyc;
               m_k = 0; e_cyc = '0; m_setup = SETUP; m_phase = 1;
             end
           end
        1: if (abort) m_phase = 0;
           else begin
             m_setup--;
             if (m_setup == 0) begin m_phase = 2; m_wd = 0; end
           end
        2, 3: if (abort) m_phase = 0;
           else if (valid) begin
             m_k++;
             e_win = 1'b1;
             e_cyc = CW'(m_k / longint'(e_ptos));
             m_phase = (m_k == longint'(e_ptos) * longint'(m_n)) ? 4 : 3;
           end
`ifdef DAC_SEQ_TIMEOUT_EN
           else if (m_phase == 2) begin
             if (m_wd == TO - 1) begin e_err = 1'b1; m_phase = 0; end
             else m_wd++;
           end
`endif
        default: m_phase = 0;
      endcase
    end
    e_busy = (m_phase != 0);
    e_en   = (m_phase == 2) || (m_phase == 3);
    e_done = (m_phase == 4);
  end

  always @(negedge CLK_65) begin
    chk("dac_reset_n",   dac_reset_n,   e_en);
    chk("dac_enable",    dac_enable,    e_en);
    chk("ptos_x_ciclo",  ptos_x_ciclo,  e_ptos);
    chk("seleccion_dac", seleccion_dac, e_sel);
    chk("window",        window,        e_win);
    chk("busy",          busy,          e_busy);
    chk("done",          done,          e_done);
    chk("err",           err,           e_err);
    chk("ciclos_hechos", ciclos_hechos, e_cyc);
  end

  int c_win = 0, c_done = 0, c_err = 0, c_busy = 0;
  always @(negedge CLK_65) begin
    if (window) c_win++;
    if (done)   c_done++;
    if (err)    c_err++;
    if (busy)   c_busy++;
  end

  task automatic tick();
    @(negedge CLK_65); #1;
  endtask

  task automatic req(input logic [15:0] p, input logic s, input logic [CW-1:0] n);
    ptos = p; sel = s; ncyc = n; start = 1'b1;
    tick();
    start = 1'b0;
    ptos = 16'hFFFF; ncyc = '1; sel = ~s;   // later cfg changes must be ignored
  endtask

  task automatic wait_release(output int low);
    int c;
    low = 0; c = 0;
    while (!dac_enable && c < 50) begin
      if (busy && !dac_reset_n) low++;
      tick(); c++;
    end
    chk("release_bound", c < 50, 1);
  endtask

  task automatic wait_done(input bit toggle);
    int c;
    c = 0;
    while (!done && c < 300) begin
      tick(); c++;
      if (toggle) valid = ~valid;
    end
    chk("done_bound", c < 300, 1);
    valid = 1'b0;
  endtask

  initial begin
    int low, w0, d0, e0, b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_dac_reset_n", dac_reset_n, 0);
    chk("rst_ptos", ptos_x_ciclo, 0);
    chk("rst_ciclos", ciclos_hechos, 0);
    reset = 1'b0;
    tick();

    // reset in the middle of RUN
    req(16'd8, SEL_SENO, CW'(3));
    wait_release(low);
    valid = 1'b1;
    repeat (10) tick();
    chk("mid_run_ciclos", ciclos_hechos, 1);
    reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_enable", dac_enable, 0);
    chk("async_ptos", ptos_x_ciclo, 0);
    chk("async_ciclos", ciclos_hechos, 0);
    chk("async_window", window, 0);
    tick();
    reset = 1'b0; valid = 1'b0;
    tick();

    // nominal burst, valid arrives 12 cycles after release
    w0 = c_win; d0 = c_done;
    req(16'd8, SEL_SENO, CW'(3));
    wait_release(low);
    chk("setup_low_cycles", low, SETUP);
    repeat (12) tick();
    valid = 1'b1;
    wait_done(1'b0);
    tick();
    chk("nominal_windows", c_win - w0, 24);
    chk("nominal_done_cnt", c_done - d0, 1);
    chk("nominal_ciclos", ciclos_hechos, 3);
    chk("nominal_enable_off", dac_enable, 0);
    chk("nominal_busy_off", busy, 0);

    // illegal requests
    e0 = c_err; b0 = c_busy;
    req(16'd3, SEL_SENO, CW'(1));
    tick();
    chk("illegal_ptos_err", c_err - e0, 1);
    req(16'd8, SEL_CONST, CW'(0));
    tick();
    chk("illegal_n_err", c_err - e0, 2);
    chk("illegal_busy", c_busy - b0, 0);
    chk("illegal_ptos_kept", ptos_x_ciclo, 8);
    chk("illegal_ciclos_kept", ciclos_hechos, 3);

    // gapped valid
    w0 = c_win; d0 = c_done;
    req(16'd4, SEL_CONST, CW'(2));
    wait_release(low);
    valid = 1'b1;
    wait_done(1'b1);
    tick();
    chk("gap_windows", c_win - w0, 8);
    chk("gap_done_cnt", c_done - d0, 1);
    chk("gap_ciclos", ciclos_hechos, 2);
    chk("gap_sel", seleccion_dac, SEL_CONST);

    // abort on the final sample
    w0 = c_win; d0 = c_done;
    req(16'd4, SEL_SENO, CW'(1));
    wait_release(low);
    valid = 1'b1;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_enable", dac_enable, 0);
    chk("abort_ciclos", ciclos_hechos, 0);
    chk("abort_windows", c_win - w0, 3);
    tick(); tick();
    chk("abort_no_done", c_done - d0, 0);

`ifdef DAC_SEQ_TIMEOUT_EN
    begin
      int s, c;
      e0 = c_err;
      req(16'd4, SEL_SENO, CW'(1));
      wait_release(low);
      s = 0; c = 0;
      while (!err && c < 100) begin
        if (dac_enable) s++;
        tick(); c++;
      end
      chk("timeout_settle_cycles", s, 16);
      chk("timeout_err", c_err - e0, 1);
      chk("timeout_enable", dac_enable, 0);
      chk("timeout_busy", busy, 0);
    end
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
